// File: rtl/alu_control_if.sv
// alu_control_if: request fields and registered result of the ALU control decoder
interface alu_control_if;
  logic       in_valid;
  logic [1:0] aluop;
  logic [6:0] func7;
  logic [2:0] func3;
  logic [3:0] aluctl;
  logic       out_valid;
  logic       illegal;
  modport master (output in_valid, aluop, func7, func3, input aluctl, out_valid, illegal);
  modport slave (input in_valid, aluop, func7, func3, output aluctl, out_valid, illegal);
endinterface

// File: rtl/alu_control.sv
// alu_control: aluop/func7/func3 to registered 4-bit ALU select; ALU_CONTROL_MULDIV_EN adds M-extension codes
module alu_control #(
  parameter logic [3:0] RESET_CTL = 4'b0010
) (
  input logic         clk,
  input logic         rst_n,
  alu_control_if.slave bus
);
  localparam logic [3:0] AND_C = 4'b0000, OR_C = 4'b0001, ADD_C = 4'b0010, XOR_C = 4'b0011;
  localparam logic [3:0] SLL_C = 4'b0100, SRL_C = 4'b0101, SUB_C = 4'b0110, SRA_C = 4'b0111;
  localparam logic [3:0] SLT_C = 4'b1000, SLTU_C = 4'b1001;
  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000;
`ifdef ALU_CONTROL_MULDIV_EN
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
`endif
  logic [3:0] ctl_d, ctl_q;
  logic       ill_d, ill_q, vld_q;
  // combinational decode; anything unsupported becomes ADD with illegal set
  always_comb begin
    ctl_d = ADD_C;
    ill_d = 1'b0;
    case (bus.aluop)
      2'b00: ctl_d = ADD_C;
      2'b01: ctl_d = SUB_C;
      2'b10:
        case (bus.func7)
          F7_BASE:
            case (bus.func3)
              3'b000: ctl_d = ADD_C;
              3'b001: ctl_d = SLL_C;
              3'b010: ctl_d = SLT_C;
              3'b011: ctl_d = SLTU_C;
              3'b100: ctl_d = XOR_C;
              3'b101: ctl_d = SRL_C;
              3'b110: ctl_d = OR_C;
              3'b111: ctl_d = AND_C;
              default: ill_d = 1'b1;
            endcase
          F7_ALT:
            case (bus.func3)
              3'b000: ctl_d = SUB_C;
              3'b101: ctl_d = SRA_C;
              default: ill_d = 1'b1;
            endcase
`ifdef ALU_CONTROL_MULDIV_EN
          F7_MULDIV:
            case (bus.func3)
              3'b000: ctl_d = 4'b1010;
              3'b001: ctl_d = 4'b1011;
              3'b011: ctl_d = 4'b1100;
              3'b100: ctl_d = 4'b1101;
              3'b101: ctl_d = 4'b1110;
              3'b110: ctl_d = 4'b1111;
              default: ill_d = 1'b1;
            endcase
`endif
          default: ill_d = 1'b1;
        endcase
      2'b11:
        case (bus.func3)
          3'b000: ctl_d = ADD_C;
          3'b001: {ctl_d, ill_d} = (bus.func7 == F7_BASE) ? {SLL_C, 1'b0} : {ADD_C, 1'b1};
          3'b010: ctl_d = SLT_C;
          3'b011: ctl_d = SLTU_C;
          3'b100: ctl_d = XOR_C;
          3'b101: {ctl_d, ill_d} = (bus.func7 == F7_BASE) ? {SRL_C, 1'b0} :
                                   (bus.func7 == F7_ALT)  ? {SRA_C, 1'b0} : {ADD_C, 1'b1};
          3'b110: ctl_d = OR_C;
          3'b111: ctl_d = AND_C;
          default: ill_d = 1'b1;
        endcase
      default: ill_d = 1'b1;
    endcase
  end
  // result registers load only on a request; valid strobe follows in_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q <= RESET_CTL;
      ill_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        ctl_q <= ctl_d;
        ill_q <= ill_d;
      end
    end
  end
  assign bus.aluctl    = ctl_q;
  assign bus.illegal   = ill_q;
  assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control: random and directed decode requests checked against a table-driven reference
module tb_alu_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  alu_control_if bus();
  alu_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int n_vec = 0;
  int n_err = 0;
  logic [4:0] tbl [4096];
  logic [3:0] exp_ctl = 4'd2;
  logic       exp_ill = 1'b0;
  logic       exp_vld = 1'b0;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, want, $time);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, " aluctl"}, {4'd0, bus.aluctl}, {4'd0, exp_ctl});
    chk({tag, " illegal"}, {7'd0, bus.illegal}, {7'd0, exp_ill});
    chk({tag, " out_valid"}, {7'd0, bus.out_valid}, {7'd0, exp_vld});
  endtask
  function automatic void build_table();
    logic [3:0] base [8];
    logic [3:0] md [8];
    logic [3:0] ok_i [8];
    base = '{4'd2, 4'd4, 4'd8, 4'd9, 4'd3, 4'd5, 4'd1, 4'd0};
    md   = '{4'd10, 4'd11, 4'd0, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0};
    ok_i = '{4'd1, 4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd1, 4'd1};
    for (int i = 0; i < 4096; i++) tbl[i] = {4'd2, 1'b1};
    for (int f = 0; f < 1024; f++) begin
      tbl[f] = {4'd2, 1'b0};
      tbl[1024 + f] = {4'd6, 1'b0};
    end
    for (int f3 = 0; f3 < 8; f3++) begin
      tbl[2048 + f3] = {base[f3], 1'b0};
`ifdef ALU_CONTROL_MULDIV_EN
      if (f3 != 2 && f3 != 7) tbl[2048 + 8 + f3] = {md[f3], 1'b0};
`endif
      for (int f7 = 0; f7 < 128; f7++)
        if (ok_i[f3] == 4'd1) tbl[3072 + f7 * 8 + f3] = {base[f3], 1'b0};
    end
    tbl[2048 + 32 * 8 + 0] = {4'd6, 1'b0};
    tbl[2048 + 32 * 8 + 5] = {4'd7, 1'b0};
    tbl[3072 + 1]          = {4'd4, 1'b0};
    tbl[3072 + 5]          = {4'd5, 1'b0};
    tbl[3072 + 32 * 8 + 5] = {4'd7, 1'b0};
  endfunction
  task automatic step(input logic v, input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
    logic [11:0] idx;
    bus.in_valid = v;
    bus.aluop = op;
    bus.func7 = f7;
    bus.func3 = f3;
    idx = {op, f7, f3};
    @(posedge clk);
    exp_vld = v;
    if (v) {exp_ctl, exp_ill} = tbl[idx];
    #1;
    check_all($sformatf("v=%0d op=%0d f7=%b f3=%b", v, op, f7, f3));
  endtask
  task automatic mid_reset();
    #3 rst_n = 1'b0;
    #1;
    exp_ctl = 4'd2;
    exp_ill = 1'b0;
    exp_vld = 1'b0;
    check_all("async reset");
    #2 rst_n = 1'b1;
  endtask
  initial begin
    logic [6:0] f7;
    build_table();
    bus.in_valid = 1'b0;
    bus.aluop = 2'b00;
    bus.func7 = 7'd0;
    bus.func3 = 3'd0;
    @(posedge clk);
    #1 check_all("reset");
    #2 rst_n = 1'b1;
    repeat (2) step(1'b0, 2'b10, 7'b0100000, 3'b111);
    step(1'b1, 2'b00, 7'b0000000, 3'b000);
    step(1'b1, 2'b00, 7'b0001111, 3'b010);
    step(1'b1, 2'b00, 7'b1111001, 3'b111);
    step(1'b1, 2'b01, 7'b0001001, 3'b111);
    step(1'b1, 2'b01, 7'b1111101, 3'b001);
    step(1'b1, 2'b01, 7'b0011111, 3'b101);
    step(1'b1, 2'b10, 7'b0000000, 3'b000);
    step(1'b1, 2'b10, 7'b0100000, 3'b000);
    step(1'b1, 2'b10, 7'b0000000, 3'b111);
    step(1'b1, 2'b10, 7'b0000000, 3'b110);
    step(1'b1, 2'b10, 7'b0100000, 3'b101);
    step(1'b1, 2'b10, 7'b0000000, 3'b011);
    step(1'b0, 2'b10, 7'b0100000, 3'b111);
    step(1'b1, 2'b10, 7'b0100000, 3'b111);
    step(1'b1, 2'b11, 7'b0100000, 3'b001);
    step(1'b1, 2'b11, 7'b0100000, 3'b000);
    step(1'b1, 2'b11, 7'b0100000, 3'b101);
    step(1'b1, 2'b11, 7'b0000000, 3'b001);
    step(1'b1, 2'b10, 7'b0000001, 3'b000);
    step(1'b1, 2'b10, 7'b0000001, 3'b111);
    step(1'b1, 2'b10, 7'b0000001, 3'b011);
    step(1'b1, 2'b10, 7'b0000000, 3'b100);
    mid_reset();
    step(1'b0, 2'b01, 7'b0000000, 3'b000);
    step(1'b1, 2'b01, 7'b0000000, 3'b000);
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(3))
        0: f7 = 7'b0000000;
        1: f7 = 7'b0100000;
        2: f7 = 7'b0000001;
        default: f7 = 7'($urandom);
      endcase
      step(1'($urandom_range(3) != 0), 2'($urandom), f7, 3'($urandom));
      if ($urandom_range(60) == 0) mid_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_control.md
Name:
alu_control

Overview:
- Decodes the main-decoder ALU opcode class (aluop) and the instruction func7/func3 fields into a 4-bit ALU operation select (aluctl).
- Sits between the main control decoder and the ALU in the single-cycle/pipelined RISC-V datapath.
- Output is registered: one clock of latency, with a valid strobe and an illegal-encoding flag.

Parameters:
- RESET_CTL, 4'b0010, aluctl value held in reset (ADD).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  decode request; fields are sampled when high
- aluop  input  2  00 load/store address, 01 branch compare, 10 R-type, 11 I-type ALU
- func7  input  7  instruction bits [31:25]
- func3  input  3  instruction bits [14:12]
- aluctl  output  4  ALU operation select
- out_valid  output  1  aluctl/illegal are valid this cycle
- illegal  output  1  unsupported func7/func3 combination for the given aluop

Behaviour:
- Codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001.
- The decode is combinational. Its result is registered on the rising edge of clk whenever in_valid=1.
- aluctl/illegal hold their last value when in_valid=0.
- out_valid is the registered copy of in_valid, so a result is presented 1 cycle after the request.
- Reset (rst_n=0, asynchronous, at any time including mid-stream):
  - aluctl=RESET_CTL, out_valid=0, illegal=0.
  - The first valid result appears one cycle after a valid request following reset release.
- aluop=00: ADD. func7/func3 are ignored. illegal=0.
- aluop=01: SUB. func7/func3 are ignored. illegal=0.
- aluop=10 (R-type):
  - With func7=0000000: func3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - With func7=0100000: func3 000 SUB, 101 SRA.
  - Any other func7/func3 pair is illegal.
- aluop=11 (I-type):
  - func3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND. func7 is ignored for these.
  - func3 001: SLL only when func7=0000000, else illegal.
  - func3 101: SRL when func7=0000000, SRA when func7=0100000, else illegal.
- On any illegal encoding: aluctl=ADD (0010) and illegal=1, registered like a normal result.
- X/unknown inputs are not required to be handled. All case statements carry a default that decodes to ADD/illegal.

Optional Feature:
- Macro ALU_CONTROL_MULDIV_EN.
- When defined, with aluop=10 and func7=0000001, func3 maps as follows:
  - 000 MUL 1010
  - 001 MULH 1011
  - 011 MULHU 1100
  - 100 DIV 1101
  - 101 DIVU 1110
  - 110 REM 1111
  - 010 (MULHSU) and 111 (REMU) are illegal.
- When undefined, func7=0000001 under aluop=10 is illegal for every func3.
- aluop=11 is unaffected in both cases.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> immediately aluctl=0010, out_valid=0, illegal=0. Release and issue no request -> outputs unchanged.
- aluop=00 with (func7,func3) = (0000000,000), (0001111,010), (1111001,111) -> aluctl=2 each, one cycle after in_valid, illegal=0. aluop=01 with (0001001,111), (1111101,001), (0011111,101) -> aluctl=6 each.
- aluop=10:
  - (0000000,000) -> 2
  - (0100000,000) -> 6
  - (0000000,111) -> 0
  - (0000000,110) -> 1
  - (0100000,101) -> 7
  - (0000000,011) -> 9
- Illegal cases: aluop=10 (0100000,111) -> aluctl=2, illegal=1. aluop=11 (0100000,001) -> illegal=1. aluop=11 (0100000,000) -> 2 with illegal=0.
- Handshake: back-to-back in_valid with changing fields -> one result per cycle, in order. in_valid=0 -> out_valid=0 next cycle and aluctl holds.
- MULDIV: with ALU_CONTROL_MULDIV_EN, aluop=10 (0000001,000) -> 10 and (0000001,111) -> illegal=1. Without the macro, (0000001,000) -> aluctl=2, illegal=1.
